// File: rtl/imem_boot_loader_if.sv
// Byte stream from the loader link plus the instruction-memory byte write port.
// The boot loader drives the master side; the link and memory sit on the slave side.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [7:0]            imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot sequencer: receives a length-prefixed, XOR-checksummed image over a byte stream,
// writes it into instruction memory and releases the core only after a good checksum.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_BYTES  = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.master  bus,
  output logic                core_run,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_CSUM   = 3'd4,
    S_RUN    = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [17:0] MEM_LIMIT = 18'(MEM_BYTES);

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  state_t                state_r;
  logic [15:0]           len_r;
  logic [17:0]           byte_cnt_r;
  logic [7:0]            csum_r;
  logic [15:0]           words_r;
  logic                  rx_ready_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [7:0]            wdata_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  err_r;
  logic                  run_r;

  logic                  accept_s;
  logic [15:0]           len_full_s;
  logic [17:0]           len_bytes_s;
  logic [17:0]           last_idx_s;

  assign accept_s    = bus.rx_valid & rx_ready_r;
  assign len_full_s  = {bus.rx_data, len_r[7:0]};
  // 18 bits so that even L=0xFFFF cannot alias below the memory size
  assign len_bytes_s = {len_full_s, 2'b00};
  assign last_idx_s  = {len_r, 2'b00} - 18'd1;

  // Load sequencer with all outputs held in registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      len_r      <= 16'd0;
      byte_cnt_r <= 18'd0;
      csum_r     <= 8'd0;
      words_r    <= 16'd0;
      rx_ready_r <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 8'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
      run_r      <= 1'b0;
    end else begin
      we_r <= 1'b0;
      case (state_r)
        S_IDLE, S_RUN, S_ERR: begin
          if (start) begin
            state_r    <= S_LEN_LO;
            len_r      <= 16'd0;
            byte_cnt_r <= 18'd0;
            csum_r     <= 8'd0;
            words_r    <= 16'd0;
            rx_ready_r <= 1'b1;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            run_r      <= 1'b0;
          end
        end
        S_LEN_LO: begin
          if (accept_s) begin
            len_r[7:0] <= bus.rx_data;
            state_r    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (accept_s) begin
            len_r[15:8] <= bus.rx_data;
            if (len_bytes_s > MEM_LIMIT) begin
              state_r    <= S_ERR;
              rx_ready_r <= 1'b0;
              busy_r     <= 1'b0;
              err_r      <= 1'b1;
            end else if (len_full_s == 16'd0) begin
              state_r <= S_CSUM;
            end else begin
              state_r <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept_s) begin
            we_r       <= 1'b1;
            addr_r     <= byte_cnt_r[ADDR_WIDTH-1:0];
            wdata_r    <= bus.rx_data;
            csum_r     <= csum_fold(csum_r, bus.rx_data);
            byte_cnt_r <= byte_cnt_r + 18'd1;
            if (byte_cnt_r[1:0] == 2'd3) begin
              words_r <= words_r + 16'd1;
            end
            if (byte_cnt_r == last_idx_s) begin
              state_r <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept_s) begin
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            if (bus.rx_data == csum_r) begin
              state_r <= S_RUN;
              run_r   <= 1'b1;
              done_r  <= 1'b1;
            end else begin
              state_r <= S_ERR;
              err_r   <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= S_IDLE;
          rx_ready_r <= 1'b0;
          busy_r     <= 1'b0;
          done_r     <= 1'b0;
          err_r      <= 1'b0;
          run_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rx_ready   = rx_ready_r;
  assign bus.imem_we    = we_r;
  assign bus.imem_addr  = addr_r;
  assign bus.imem_wdata = wdata_r;
  assign core_run       = run_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign words_loaded   = words_r;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table of complete load streams plus hand-written
// sequences for start/valid collision, start during a load and reset mid-load.
module tb_imem_boot_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] words_loaded;

  imem_boot_loader_if #(.ADDR_WIDTH(10)) bus ();

  imem_boot_loader #(.ADDR_WIDTH(10), .MEM_BYTES(1024)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .bus          (bus),
    .core_run     (core_run),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int addr_q[$];
  int data_q[$];

  // Log every memory write, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      addr_q.push_back(int'(bus.imem_addr));
      data_q.push_back(int'(bus.imem_wdata));
    end
  end

  typedef struct packed {
    logic [3:0]        n;
    logic [0:11][7:0]  b;
    logic              gap;
    logic [3:0]        nwr;
    logic [0:7][7:0]   wd;
    logic              exp_done;
    logic              exp_err;
    logic [15:0]       exp_words;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (bus.rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: rx_ready stayed %b for byte %0h, required 1", bus.rx_ready, b);
    end
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_run_drop", core_run, 1'b0);
    check("start_done_clr", done, 1'b0);
    check("start_err_clr", err, 1'b0);
    check("start_words_clr", words_loaded, 16'd0);
    check("start_ready", bus.rx_ready, 1'b1);
  endtask

  initial begin
    // normal load
    vecs[0] = '{n: 4'd11, b: {8'h02, 8'h00, 8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0, 8'h00},
                gap: 1'b0, nwr: 4'd8, wd: {8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00},
                exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd2};
    // bad checksum
    vecs[1] = '{n: 4'd11, b: {8'h02, 8'h00, 8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC1, 8'h00},
                gap: 1'b0, nwr: 4'd8, wd: {8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00},
                exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd2};
    // empty image
    vecs[2] = '{n: 4'd3, b: {8'h00, 8'h00, 8'h00, 72'h0},
                gap: 1'b0, nwr: 4'd0, wd: 64'h0,
                exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd0};
    // oversize: L=257 -> 1028 bytes
    vecs[3] = '{n: 4'd2, b: {8'h01, 8'h01, 80'h0},
                gap: 1'b0, nwr: 4'd0, wd: 64'h0,
                exp_done: 1'b0, exp_err: 1'b1, exp_words: 16'd0};
    // normal load with rx_valid gaps
    vecs[4] = '{n: 4'd11, b: {8'h02, 8'h00, 8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hC0, 8'h00},
                gap: 1'b1, nwr: 4'd8, wd: {8'h33, 8'h70, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00},
                exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd2};
    // reload from RUN, one word
    vecs[5] = '{n: 4'd7, b: {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13, 40'h0},
                gap: 1'b0, nwr: 4'd4, wd: {8'h13, 8'h00, 8'h00, 8'h00, 32'h0},
                exp_done: 1'b1, exp_err: 1'b0, exp_words: 16'd1};

    rst          = 1'b0;
    start        = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (3) tick();

    check("rst_ready", bus.rx_ready, 1'b0);
    check("rst_we", bus.imem_we, 1'b0);
    check("rst_addr", bus.imem_addr, 10'd0);
    check("rst_wdata", bus.imem_wdata, 8'h00);
    check("rst_run", core_run, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_words", words_loaded, 16'd0);

    rst = 1'b1;
    tick();

    // start and rx_valid together in IDLE: byte must not be taken as the length
    bus.rx_data  = 8'h05;
    bus.rx_valid = 1'b1;
    start        = 1'b1;
    check("idle_ready", bus.rx_ready, 1'b0);
    tick();
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    check("collide_busy", busy, 1'b1);
    check("collide_ready", bus.rx_ready, 1'b1);
    addr_q.delete();
    data_q.delete();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    check("collide_done", done, 1'b1);
    check("collide_run", core_run, 1'b1);
    check("collide_nwr", addr_q.size(), 32'd0);

    for (int v = 0; v < 6; v++) begin
      int nb;
      addr_q.delete();
      data_q.delete();
      do_start();
      nb = int'(vecs[v].n);
      for (int i = 0; i < nb; i++) begin
        if (i == nb - 1) check($sformatf("v%0d_run_before", v), core_run, 1'b0);
        send_byte(vecs[v].b[i]);
        if (vecs[v].gap) tick();
      end
      check($sformatf("v%0d_done", v), done, vecs[v].exp_done);
      check($sformatf("v%0d_err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d_run", v), core_run, vecs[v].exp_done);
      check($sformatf("v%0d_busy", v), busy, 1'b0);
      check($sformatf("v%0d_ready", v), bus.rx_ready, 1'b0);
      check($sformatf("v%0d_words", v), words_loaded, vecs[v].exp_words);
      check($sformatf("v%0d_nwr", v), addr_q.size(), 32'(vecs[v].nwr));
      for (int j = 0; j < addr_q.size() && j < 8; j++) begin
        check($sformatf("v%0d_addr%0d", v, j), addr_q[j], j);
        check($sformatf("v%0d_data%0d", v, j), data_q[j], 32'(vecs[v].wd[j]));
      end
      // stray bytes after completion must be ignored
      bus.rx_data  = 8'hAA;
      bus.rx_valid = 1'b1;
      repeat (3) tick();
      bus.rx_valid = 1'b0;
      check($sformatf("v%0d_stray_nwr", v), addr_q.size(), 32'(vecs[v].nwr));
      check($sformatf("v%0d_stray_done", v), done, vecs[v].exp_done);
      check($sformatf("v%0d_stray_err", v), err, vecs[v].exp_err);
      check($sformatf("v%0d_stray_words", v), words_loaded, vecs[v].exp_words);
    end

    // start during DATA is ignored; reset after the third payload byte
    addr_q.delete();
    data_q.delete();
    do_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h33);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("midstart_busy", busy, 1'b1);
    check("midstart_ready", bus.rx_ready, 1'b1);
    send_byte(8'h70);
    send_byte(8'h00);
    check("mid_we", bus.imem_we, 1'b1);
    check("mid_addr", bus.imem_addr, 10'd2);
    check("mid_wdata", bus.imem_wdata, 8'h00);
    check("mid_nwr", addr_q.size(), 32'd2);
    check("mid_addr1", addr_q.size() > 1 ? addr_q[1] : -1, 32'd1);
    rst = 1'b0;
    #1;
    check("mrst_we", bus.imem_we, 1'b0);
    check("mrst_addr", bus.imem_addr, 10'd0);
    check("mrst_ready", bus.rx_ready, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_run", core_run, 1'b0);
    check("mrst_words", words_loaded, 16'd0);
    tick();
    rst = 1'b1;
    tick();
    tick();
    check("post_rst_ready", bus.rx_ready, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_run", core_run, 1'b0);
    check("post_rst_done", done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
